// File: rtl/io_bus_responder.sv
// Board-side IO bus responder: emulates BOARDS latch/input-port boards behind an addr/strobe/data bus.
// Optional per-board latch watchdog enabled by defining IO_RESPONDER_WATCHDOG_EN.
module io_bus_responder #(
  parameter int BOARDS           = 16,
  parameter int INSTALLED_BOARDS = 2,
  parameter int WDT_CYCLES       = 4096
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [3:0]            addr_i,
  input  logic [1:0]            enable_n_i,
  inout  wire  [7:0]            data_io,
  input  logic [BOARDS*8-1:0]   board_in_i,
  output logic [BOARDS*8-1:0]   board_out_o,
  output logic [BOARDS-1:0]     write_strobe_o,
  output logic                  bus_error_o,
  output logic [BOARDS-1:0]     wdt_expired_o
);

  logic [1:0]          enable_q;
  logic [BOARDS*8-1:0] sync1_q;
  logic [BOARDS*8-1:0] sync2_q;
  logic [BOARDS*8-1:0] board_out_q;
  logic [BOARDS-1:0]   wstrobe_q;
  logic                bus_err_q;

  logic       single_sel;
  logic       bank;
  logic [3:0] idx;
  logic       installed;
  logic       start;
  logic       wr_hit;
  logic       rd_en;

  assign single_sel = (enable_n_i == 2'b01) || (enable_n_i == 2'b10);
  assign bank       = (enable_n_i == 2'b01);
  assign idx        = {bank, addr_i[2:0]};
  assign installed  = (int'(idx) < INSTALLED_BOARDS) && (int'(idx) < BOARDS);
  assign start      = |(enable_n_i & ~enable_q);
  assign wr_hit     = start && single_sel && addr_i[3] && installed;
  // Read data follows addr/enable combinationally; reset forces the bus released.
  assign rd_en      = !Rst && single_sel && !addr_i[3] && installed;
  assign data_io    = rd_en ? sync2_q[{idx, 3'b000} +: 8] : 8'hzz;

`ifdef IO_RESPONDER_WATCHDOG_EN
  localparam int CW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [CW-1:0]     wdt_cnt_q [BOARDS];
  logic [BOARDS-1:0] wdt_exp_q;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      enable_q    <= 2'b00;
      sync1_q     <= '0;
      sync2_q     <= '0;
      board_out_q <= '0;
      wstrobe_q   <= '0;
      bus_err_q   <= 1'b0;
`ifdef IO_RESPONDER_WATCHDOG_EN
      wdt_exp_q   <= '0;
      for (int n = 0; n < BOARDS; n++) wdt_cnt_q[n] <= '0;
`endif
    end else begin
      enable_q <= enable_n_i;
      sync1_q  <= board_in_i;
      sync2_q  <= sync1_q;
      if (enable_n_i == 2'b11) bus_err_q <= 1'b1;
      if (wr_hit) begin
        board_out_q[{idx, 3'b000} +: 8] <= data_io;
        wstrobe_q <= BOARDS'(1) << idx;
      end else begin
        wstrobe_q <= '0;
      end
`ifdef IO_RESPONDER_WATCHDOG_EN
      // Expired counters saturate; only a fresh write re-arms them.
      for (int n = 0; n < BOARDS; n++) begin
        if (n < INSTALLED_BOARDS) begin
          if (wr_hit && int'(idx) == n) begin
            wdt_cnt_q[n] <= '0;
            wdt_exp_q[n] <= 1'b0;
          end else if (!wdt_exp_q[n]) begin
            if (wdt_cnt_q[n] == CW'(WDT_CYCLES - 1)) begin
              wdt_exp_q[n]          <= 1'b1;
              board_out_q[n*8 +: 8] <= 8'h00;
            end else begin
              wdt_cnt_q[n] <= wdt_cnt_q[n] + 1'b1;
            end
          end
        end
      end
`endif
    end
  end

  assign board_out_o    = board_out_q;
  assign write_strobe_o = wstrobe_q;
  assign bus_error_o    = bus_err_q;
`ifdef IO_RESPONDER_WATCHDOG_EN
  assign wdt_expired_o  = wdt_exp_q;
`else
  assign wdt_expired_o  = '0;
`endif

endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Board-side end of the IO register bus: emulates up to BOARDS peripheral boards, each with one 8-bit output latch written by the bus master and one 8-bit input port read by it. Sits on the far side of addr/enable/data from the IO register scanner, either inside the FPGA for hardware-free emulation or on a board controller. Decodes bank/slot/direction per strobe, latches writes once per strobe, drives read data during read strobes, and flags bus protocol errors.

## Interface
- BOARDS, 16: number of board slots addressable (2 banks x 8 slots).
- INSTALLED_BOARDS, 2: boards actually present (indices 0..INSTALLED_BOARDS-1); others are absent.
- WDT_CYCLES, 4096: watchdog timeout in Clk cycles; only used with the watchdog enabled.
- Clk  input  1  system clock, same domain as bus master.
- Rst  input  1  asynchronous, active-high reset.
- addr_i  input  4  bit3 = direction (1 master writes board, 0 master reads board); bits2:0 = slot in bank.
- enable_n_i  input  2  strobe lines, asserted high for one cycle: bit0 selects bank 1 (board 8+slot), bit1 selects bank 0 (board slot).
- data_io  inout  8  shared data bus; driven only during read strobes to installed boards, else Z.
- board_in_i  input  BOARDS*8  raw board input ports, board n at [8n+7:8n]; asynchronous to Clk.
- board_out_o  output  BOARDS*8  output latches, board n at [8n+7:8n].
- write_strobe_o  output  BOARDS  one-cycle pulse when board n's latch is updated.
- bus_error_o  output  1  sticky protocol-error flag.
- wdt_expired_o  output  BOARDS  per-board watchdog-expired flags.

## Operation
- Board index = {bank, addr_i[2:0]}; bank = 1 when enable_n_i == 2'b01, 0 when 2'b10.
- Inputs: board_in_i passes through a 2-flop synchronizer per bit; sync_in[n] is the read source.
- Strobe edge: enable_q registers enable_n_i; an access starts on a cycle with (enable_n_i & ~enable_q) != 0. Strobe held high >1 cycle still yields one access.
- Write access (addr_i[3]=1, installed board): data_io sampled at the Clk edge ending the first strobe cycle into board_out_o[n]; write_strobe_o[n] pulses the following cycle.
- Read access (addr_i[3]=0, installed board): data_io = sync_in[n] combinationally for every cycle enable_n_i is nonzero and addr_i[3]=0; released to Z when enable drops.
- Absent board (index >= INSTALLED_BOARDS): writes ignored, reads leave bus Z; not an error.
- Error: enable_n_i == 2'b11 on any cycle sets bus_error_o; no latch update and no drive that cycle. Cleared only by Rst.
- Only one board can be addressed per cycle; write_strobe_o is one-hot or zero.

## Timing
- Reset: board_out_o = 0, write_strobe_o = 0, bus_error_o = 0, wdt_expired_o = 0, enable_q = 0, synchronizers = 0, data_io = Z.
- Write latency: strobe cycle k -> board_out_o valid at cycle k+1, write_strobe_o high in k+1 only.
- Read latency: board_in_i change visible on bus after 2 Clk edges; bus driven within the strobe cycle (combinational from addr/enable).
- Master protocol: addr stable ≥1 cycle before and during strobe; responder does not require it for writes (sampled at strobe edge) but read data follows addr combinationally.
- Reset asserted mid-strobe: latches clear immediately, bus Z; access after reset release requires a new rising strobe edge (enable_q resets to 0, so a still-high strobe counts once).
- Back-to-back strobes to the same board with one low cycle between them: two accesses.

## Configuration
- IO_RESPONDER_WATCHDOG_EN defined: per-installed-board counter reloads to 0 on each write; when it reaches WDT_CYCLES-1 the board's latch clears to 0 and wdt_expired_o[n] sets; next write clears the flag and reloads. Counter saturates while expired.
- Undefined: no counters, latches hold indefinitely, wdt_expired_o tied to 0.

## Test plan
- Reset then write: addr_i=4'b1001, enable_n_i=2'b10 one cycle, data_io=8'hA5 -> board_out_o[15:8]=8'hA5 next cycle, write_strobe_o=16'h0002 one cycle.
- Read: board_in_i[7:0]=8'h3C held 3 cycles, addr_i=4'b0000, enable_n_i=2'b10 -> data_io=8'h3C during strobe, Z before and after.
- Bank 1 absent: INSTALLED_BOARDS=2, addr_i=4'b1000, enable_n_i=2'b01, data=8'hFF -> no latch change, no write_strobe_o; read to same leaves data_io Z.
- Held strobe: write strobe held 3 cycles, data changes 8'h11->8'h22 on cycle 2 -> latch = 8'h11, one write_strobe_o pulse.
- Error: enable_n_i=2'b11 with write addr -> bus_error_o=1 persists, latches unchanged; Rst clears it.
- Watchdog (macro on, WDT_CYCLES=16): write 8'h55 to board 0, no further writes -> latch 0 and wdt_expired_o[0]=1 after 16 cycles; next write 8'h01 clears flag.
